// File: rtl/rng_pkg.sv
// Shared types and combinational helpers for the LFSR random source.
// Helpers work on a fixed 64-bit container; callers cast to their own width.
package rng_pkg;

  localparam int          MAX_W           = 64;
  localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;

  typedef enum logic {IDLE, DRAW} rng_state_t;

  // One Fibonacci step: shift left, feedback bit enters at bit 0.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] taps);
    return {state[MAX_W-2:0], ^(state & taps)};
  endfunction

  // Sets every bit below the most significant one; 0 stays 0.
  function automatic logic [MAX_W-1:0] smear_mask(input logic [MAX_W-1:0] x);
    logic [MAX_W-1:0] m;
    m = x;
    for (int i = 1; i < MAX_W; i = i * 2) m = m | (m >> i);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and all-zero lockup recovery.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS_16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'h1ACE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_next;

  assign state_next = WIDTH'(lfsr_step(MAX_W'(state), MAX_W'(TAPS)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else if (state == '0) begin
      // Zero is a fixed point of the shift; escape it whether stepping or not.
      state <= SEED;
    end else if (step) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Bounded random draws in [0, range_max] via masked rejection sampling
// on top of a free-running or on-demand LFSR.
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS_16),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'h1ACE),
  parameter int               OUT_W     = 6,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] range_max,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic             rnd_bit,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  rng_state_t       fsm;
  logic [OUT_W-1:0] rmax;
  logic [OUT_W-1:0] mask;
  logic [TRY_W-1:0] tries;
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             last_try;
  logic             core_step;

  assign cand     = lfsr_state[OUT_W-1:0] & mask;
  assign accept   = (cand <= rmax);
  assign last_try = (tries == LAST_TRY);
  assign rnd_bit  = ^(lfsr_state & TAPS);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    core_step = 1'b0;
    case (fsm)
      IDLE: core_step = enable | req;
      DRAW: core_step = !accept && !last_try;
    endcase
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .step     (core_step),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr_state)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm   <= IDLE;
      rmax  <= '0;
      mask  <= '0;
      tries <= '0;
      value <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (seed_load) begin
        fsm  <= IDLE;
        busy <= 1'b0;
      end else begin
        case (fsm)
          IDLE: begin
            if (req) begin
              rmax  <= range_max;
              mask  <= OUT_W'(smear_mask(MAX_W'(range_max)));
              tries <= '0;
              fsm   <= DRAW;
              busy  <= 1'b1;
            end
          end
          DRAW: begin
            if (accept) begin
              value <= cand;
              valid <= 1'b1;
              fsm   <= IDLE;
              busy  <= 1'b0;
            end else if (last_try) begin
              // cand <= mask < 2*(rmax+1), so one subtraction lands in range.
              value <= OUT_W'({1'b0, cand} - ({1'b0, rmax} + (OUT_W + 1)'(1)));
              valid <= 1'b1;
              fsm   <= IDLE;
              busy  <= 1'b0;
            end else begin
              tries <= tries + TRY_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed self-checking bench for lfsr_rng; a second instance with a single
// try exercises the fallback path deterministically.
module tb_lfsr_rng;

  localparam logic [15:0] SEED = 16'h1ACE;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        enable    = 1'b0;
  logic        seed_load = 1'b0;
  logic        req       = 1'b0;
  logic [15:0] seed_in   = '0;
  logic [5:0]  range_max = '0;

  logic        busy, valid, rnd_bit;
  logic [5:0]  value;
  logic [15:0] lfsr_state;
  logic        fb_busy, fb_valid, fb_rnd_bit;
  logic [5:0]  fb_value;
  logic [15:0] fb_state;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_rng dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .req        (req),
    .range_max  (range_max),
    .busy       (busy),
    .valid      (valid),
    .value      (value),
    .rnd_bit    (rnd_bit),
    .lfsr_state (lfsr_state)
  );

  lfsr_rng #(.MAX_TRIES(1)) dut_fb (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .req        (req),
    .range_max  (range_max),
    .busy       (fb_busy),
    .valid      (fb_valid),
    .value      (fb_value),
    .rnd_bit    (fb_rnd_bit),
    .lfsr_state (fb_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    seed_load = 1'b0;
    req       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int hist [7];
    int bad_range, max_gap, min_gap, timeouts, gap, extra, steps;

    // Reset values and first hand-stepped states from SEED.
    do_reset();
    check("reset_state", 32'(lfsr_state), 32'h1ACE);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rnd_bit", 32'(rnd_bit), 32'h1);
    enable = 1'b1;
    tick();
    check("step1", 32'(lfsr_state), 32'h359D);
    tick();
    tick();
    check("step3", 32'(lfsr_state), 32'hD677);
    enable = 1'b0;

    // Seed load and single step.
    seed_load = 1'b1;
    seed_in   = 16'h0001;
    tick();
    seed_load = 1'b0;
    check("seed_0001", 32'(lfsr_state), 32'h0001);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("seed_0001_step", 32'(lfsr_state), 32'h0002);

    // Zero seed is replaced; a forced zero state recovers to SEED.
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("seed_zero", 32'(lfsr_state), 32'h1ACE);
    force dut.u_core.state = 16'h0000;
    #1;
    release dut.u_core.state;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("lockup_recover", 32'(lfsr_state), 32'h1ACE);

    // range_max=0: accepted first try, two-cycle latency.
    do_reset();
    req       = 1'b1;
    range_max = 6'd0;
    tick();
    req = 1'b0;
    check("r0_busy_c1", 32'(busy), 32'h1);
    check("r0_valid_c1", 32'(valid), 32'h0);
    tick();
    check("r0_valid_c2", 32'(valid), 32'h1);
    check("r0_value_c2", 32'(value), 32'h0);
    check("r0_busy_c2", 32'(busy), 32'h0);
    tick();
    check("r0_valid_pulse", 32'(valid), 32'h0);

    // range_max=6 from SEED: state steps to 359D, cand = 5.
    do_reset();
    req       = 1'b1;
    range_max = 6'd6;
    tick();
    req = 1'b0;
    tick();
    check("r6_valid", 32'(valid), 32'h1);
    check("r6_value", 32'(value), 32'h5);

    // range_max=4: cand 5 rejected, then 6B3B gives 3. Requests while busy
    // and range_max changes during DRAW must have no effect.
    do_reset();
    req       = 1'b1;
    range_max = 6'd4;
    tick();
    range_max = 6'd0;
    check("r4_busy_c1", 32'(busy), 32'h1);
    tick();
    check("r4_valid_c2", 32'(valid), 32'h0);
    check("r4_busy_c2", 32'(busy), 32'h1);
    check("fb_r4_valid_c2", 32'(fb_valid), 32'h1);
    check("fb_r4_value_c2", 32'(fb_value), 32'h0);
    tick();
    req = 1'b0;
    check("r4_valid_c3", 32'(valid), 32'h1);
    check("r4_value_c3", 32'(value), 32'h3);
    check("r4_busy_c3", 32'(busy), 32'h0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) extra++;
    end
    check("r4_no_extra_valid", 32'(extra), 32'h0);
    check("r4_value_held", 32'(value), 32'h3);

    // Fallback with one try: 0403 -> 0807, cand 7 > 4, result 7 - 5 = 2.
    do_reset();
    seed_load = 1'b1;
    seed_in   = 16'h0403;
    tick();
    seed_load = 1'b0;
    req       = 1'b1;
    range_max = 6'd4;
    tick();
    req = 1'b0;
    tick();
    check("fb_valid", 32'(fb_valid), 32'h1);
    check("fb_value", 32'(fb_value), 32'h2);

    // seed_load during a draw aborts it silently.
    do_reset();
    req       = 1'b1;
    range_max = 6'd6;
    tick();
    req = 1'b0;
    check("abort_busy_c1", 32'(busy), 32'h1);
    seed_load = 1'b1;
    seed_in   = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    check("abort_valid_c2", 32'(valid), 32'h0);
    check("abort_busy_c2", 32'(busy), 32'h0);
    check("abort_state", 32'(lfsr_state), 32'hBEEF);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) extra++;
    end
    check("abort_no_valid", 32'(extra), 32'h0);

    // Back-to-back draws over 0..6: range, spread and latency bound.
    do_reset();
    foreach (hist[v]) hist[v] = 0;
    bad_range = 0;
    max_gap   = 0;
    timeouts  = 0;
    req       = 1'b1;
    range_max = 6'd6;
    for (int d = 0; d < 10000; d++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!valid && gap < 20);
      if (!valid) begin
        timeouts++;
        break;
      end
      if (gap > max_gap) max_gap = gap;
      if (value > 6'd6) bad_range++;
      else hist[value]++;
    end
    req = 1'b0;
    tick();
    tick();
    check("r6_timeouts", 32'(timeouts), 32'h0);
    check("r6_out_of_range", 32'(bad_range), 32'h0);
    check("r6_max_gap_le_9", 32'(max_gap <= 9), 32'h1);
    foreach (hist[v]) check($sformatf("r6_hist_%0d_ge_1000", v), 32'(hist[v] >= 1000), 32'h1);

    // range_max=63: mask is all ones, every draw accepted in two cycles.
    do_reset();
    max_gap   = 0;
    min_gap   = 100;
    req       = 1'b1;
    range_max = 6'd63;
    for (int d = 0; d < 50; d++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!valid && gap < 20);
      if (gap > max_gap) max_gap = gap;
      if (gap < min_gap) min_gap = gap;
    end
    req = 1'b0;
    tick();
    check("r63_max_gap", 32'(max_gap), 32'h2);
    check("r63_min_gap", 32'(min_gap), 32'h2);

    // Full period: SEED recurs after exactly 2^16 - 1 steps.
    do_reset();
    enable = 1'b1;
    steps  = 0;
    do begin
      tick();
      steps++;
    end while (lfsr_state != SEED && steps < 70000);
    enable = 1'b0;
    check("period", 32'(steps), 32'd65535);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
